blink_sequencer: RTL and testbench

- Sequences playback of the stored colour pattern to the player LEDs during the game FSM's blink phase.
- Enabled by the game FSM's on_blinker (port start). Reads pattern entries 0..level-1 from the synchronous pattern memory, lights one LED per entry for a programmable on/off time, then pulses blinker_done back to the game FSM.
- Owns the pattern memory read port while running.

---
 rtl/blink_sequencer.sv | 162 ++++++++++++++++
 tb/tb_blink_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sequencer.sv
// Plays back pattern entries 0..level-1 as timed one-hot LED flashes, then pulses blinker_done.
// state | meaning: IDLE wait for start; FETCH read strobe; WAIT latch colour; ON lit; OFF dark gap; DONE pulse; HOLD wait for start low
module blink_sequencer #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int LEVEL_W    = 4,
    parameter int NUM_LEDS   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [LEVEL_W-1:0]          level,
    output logic                        mem_rd_en,
    output logic [LEVEL_W-1:0]          mem_addr,
    input  logic [$clog2(NUM_LEDS)-1:0] mem_rdata,
    output logic [NUM_LEDS-1:0]         led,
    output logic                        blinker_done,
    output logic                        busy
);

    localparam int COL_W   = $clog2(NUM_LEDS);
    localparam int T_MAX   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W = $clog2(T_MAX + 1);
    localparam logic [TIMER_W-1:0] T_ON  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_OFF = TIMER_W'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ON,
        S_OFF,
        S_DONE,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [LEVEL_W-1:0]   idx_q, idx_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [COL_W-1:0]     colour_q, colour_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 rd_en_q, rd_en_d;
    logic [LEVEL_W-1:0]   addr_q, addr_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [COL_W-1:0] c);
        return NUM_LEDS'(1) << c;
    endfunction

    // Outputs are computed for the state being entered so they register alongside it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        level_d  = level_q;
        timer_d  = timer_q;
        colour_d = colour_q;
        addr_d   = addr_q;
        led_d    = '0;
        rd_en_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (level != '0) begin
                        level_d = level;
                        idx_d   = '0;
                        addr_d  = '0;
                        rd_en_d = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                state_d = start ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    colour_d = mem_rdata;
                    timer_d  = T_ON;
                    led_d    = onehot(mem_rdata);
                    state_d  = S_ON;
                end
            end
            S_ON: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    timer_d = T_OFF;
                    state_d = S_OFF;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                    led_d   = onehot(colour_q);
                end
            end
            S_OFF: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (idx_q + LEVEL_W'(1) == level_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + LEVEL_W'(1);
                    addr_d  = idx_q + LEVEL_W'(1);
                    rd_en_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            level_q  <= '0;
            timer_q  <= '0;
            colour_q <= '0;
            led_q    <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            level_q  <= level_d;
            timer_q  <= timer_d;
            colour_q <= colour_d;
            led_q    <= led_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign led          = led_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = addr_q;
    assign blinker_done = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: cycle-index model checked every cycle plus directed literal checks.
module tb_blink_sequencer;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int S   = 2 + ON + OFF;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] level;
    logic       mem_rd_en;
    logic [3:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [3:0] led;
    logic       blinker_done, busy;

    blink_sequencer #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .LEVEL_W(4), .NUM_LEDS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .level(level),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .led(led), .blinker_done(blinker_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [1:0] mem [16];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a run is described only by how many edges have passed since start was seen.
    int m_mode = 0;
    int m_k = 0;
    int m_L = 0;
    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0;
            m_k    = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_k    = 1;
                m_L    = int'(level);
            end
        end else if (m_k <= m_L * S) begin
            if (!start) m_mode = 0;
            else m_k++;
        end else if (m_k == m_L * S + 1) begin
            m_k++;
        end else if (!start) begin
            m_mode = 0;
        end
    end

    always @(negedge clk) begin
        int step, p;
        logic [3:0] e_led, e_addr;
        logic e_rd, e_done, e_busy;
        if (check_en) begin
            e_led = '0; e_rd = 1'b0; e_addr = '0; e_done = 1'b0; e_busy = 1'b0;
            if (m_mode == 1) begin
                e_busy = 1'b1;
                if (m_k <= m_L * S) begin
                    step = (m_k - 1) / S;
                    p    = (m_k - 1) % S;
                    if (p == 0) begin
                        e_rd   = 1'b1;
                        e_addr = 4'(step);
                    end else if (p >= 2 && p < 2 + ON) begin
                        e_led = 4'b0001 << mem[step];
                    end
                end else if (m_k == m_L * S + 1) begin
                    e_done = 1'b1;
                end
            end
            chk("led", led, e_led);
            chk("mem_rd_en", mem_rd_en, e_rd);
            chk("blinker_done", blinker_done, e_done);
            chk("busy", busy, e_busy);
            if (e_rd) chk("mem_addr", mem_addr, e_addr);
        end
    end

    int done_cnt, done_at;
    int rd_cyc[$];
    int rd_addr[$];
    logic [3:0] led_at [128];
    logic       busy_at [128];

    task automatic run(input int lvl, input int ncyc, input int chg_at, input int chg_lvl,
                       input int abort_at, input int rst_at);
        level = 4'(lvl);
        start = 1'b1;
        done_cnt = 0;
        done_at  = -1;
        rd_cyc.delete();
        rd_addr.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (blinker_done) begin done_cnt++; done_at = c; end
            if (mem_rd_en) begin rd_cyc.push_back(c); rd_addr.push_back(int'(mem_addr)); end
            led_at[c]  = led;
            busy_at[c] = busy;
            if (c == chg_at) level = 4'(chg_lvl);
            if (c == abort_at) start = 1'b0;
            if (c == rst_at) begin reset = 1'b0; start = 1'b0; end
            if (rst_at > 0 && c == rst_at + 1) reset = 1'b1;
        end
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_drop", busy, 1'b0);
    endtask

    initial begin
        int led_any, busy_cnt;
        for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        reset = 1'b0; start = 1'b0; level = '0;
        @(negedge clk);
        chk("rst_led", led, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd", mem_rd_en, 1'b0);
        chk("rst_addr", mem_addr, 4'b0);
        chk("rst_done", blinker_done, 1'b0);
        check_en = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // basic three-step playback, held 10 cycles in HOLD
        run(3, 32, 0, 0, 0, 0);
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_done_at", done_at, 22);
        chk("s1_rd_cnt", rd_cyc.size(), 3);
        for (int i = 0; i < 3 && i < rd_cyc.size(); i++) begin
            chk("s1_rd_cyc", rd_cyc[i], 1 + 7 * i);
            chk("s1_rd_addr", rd_addr[i], i);
        end
        chk("s1_led3", led_at[3], 4'b0100);
        chk("s1_led5", led_at[5], 4'b0100);
        chk("s1_led6", led_at[6], 4'b0000);
        chk("s1_led10", led_at[10], 4'b0001);
        chk("s1_led17", led_at[17], 4'b1000);
        chk("s1_led21", led_at[21], 4'b0000);
        busy_cnt = 0;
        for (int c = 23; c <= 32; c++) busy_cnt += int'(busy_at[c]);
        chk("s3_hold_busy", busy_cnt, 10);
        drop_start();
        @(negedge clk);

        // replay after returning to IDLE
        run(3, 24, 0, 0, 0, 0);
        chk("s3_replay_done_at", done_at, 22);
        chk("s3_replay_rd_cnt", rd_cyc.size(), 3);
        drop_start();

        // level zero goes straight to DONE
        run(0, 8, 0, 0, 0, 0);
        chk("s2_done_at", done_at, 1);
        chk("s2_done_cnt", done_cnt, 1);
        chk("s2_rd_cnt", rd_cyc.size(), 0);
        led_any = 0;
        for (int c = 1; c <= 8; c++) led_any |= int'(led_at[c]);
        chk("s2_led_never", led_any, 0);
        chk("s2_hold_busy", busy_at[8], 1'b1);
        drop_start();

        // abort during ON of step 2
        run(3, 30, 0, 0, 10, 0);
        chk("s4_led_before", led_at[10], 4'b0001);
        chk("s4_led_after", led_at[11], 4'b0000);
        chk("s4_busy_after", busy_at[11], 1'b0);
        chk("s4_no_done", done_cnt, 0);
        @(negedge clk);

        // level changed mid-run is ignored
        run(3, 24, 5, 7, 0, 0);
        chk("s5_done_at", done_at, 22);
        chk("s5_rd_cnt", rd_cyc.size(), 3);
        chk("s5_done_cnt", done_cnt, 1);
        drop_start();

        // reset during OFF of step 1, then replay from address 0
        run(3, 12, 0, 0, 0, 6);
        chk("s6_led", led_at[7], 4'b0000);
        chk("s6_busy", busy_at[7], 1'b0);
        chk("s6_no_done", done_cnt, 0);
        run(3, 24, 0, 0, 0, 0);
        chk("s6_first_addr", (rd_addr.size() > 0) ? rd_addr[0] : -1, 0);
        chk("s6_done_at", done_at, 22);
        drop_start();

        // maximum level: entries 0..14, no wrap
        run(15, 110, 0, 0, 0, 0);
        chk("max_done_at", done_at, 1 + 15 * S);
        chk("max_rd_cnt", rd_cyc.size(), 15);
        chk("max_last_addr", (rd_addr.size() == 15) ? rd_addr[14] : -1, 14);
        drop_start();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
